flower_anim_ctrl: RTL
=====================

FLOWER_ANIM_CTRL -- requirements
Module: flower_anim_ctrl

Interface
REQ-001 Parameter ACTIVE_STATUS, default 4'd5: game status value that enables the flower animation.
REQ-002 Parameter NUM_FRAMES, default 3: number of sprite frames in the sequence, legal range 1..7.
REQ-003 Parameter FRAME_TICKS, default 120: frame_tick pulses each frame is displayed, legal range 1..255.
REQ-004 Parameter LOOP, default 0: 1 = wrap to frame 1 after the last frame; 0 = hold the last frame.
REQ-005 Clk  input  1  system clock; all state changes on its rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 frame_tick  input  1  one-Clk-cycle pulse, once per video frame (vsync).
REQ-008 status  input  4  current game status.
REQ-009 pause  input  1  level; while 1, frame_tick is ignored.
REQ-010 skip  input  1  one-cycle pulse; advance to the next frame immediately.
REQ-011 frame_sel  output  3  0 = no sprite; 1..NUM_FRAMES = sprite ROM select.
REQ-012 tick_cnt  output  8  ticks elapsed in the current frame.
REQ-013 busy  output  1  1 in PLAY state.
REQ-014 anim_done  output  1  one-cycle pulse on entry to HOLD.

Function
REQ-015 The block SHALL implement the states IDLE, PLAY and HOLD, all registered.
REQ-016 IDLE: frame_sel=0, tick_cnt=0, busy=0; if status==ACTIVE_STATUS, the next state SHALL be PLAY with frame_sel=1 and tick_cnt=0.
REQ-017 PLAY: on frame_tick with pause=0, tick_cnt SHALL increment by 1 when tick_cnt<FRAME_TICKS-1.
REQ-018 PLAY expiry: on frame_tick with pause=0 and tick_cnt==FRAME_TICKS-1, the block SHALL advance the frame.
REQ-019 PLAY skip: a skip pulse SHALL advance the frame regardless of pause or tick_cnt.
REQ-020 Advance SHALL set tick_cnt=0; if frame_sel<NUM_FRAMES, frame_sel SHALL increment by 1.
REQ-021 Advance at frame_sel==NUM_FRAMES: with LOOP=1, frame_sel SHALL become 1 and the state SHALL remain PLAY; with LOOP=0, the state SHALL become HOLD and anim_done SHALL be 1 for exactly that next cycle.
REQ-022 Simultaneous skip and tick-expiry in one cycle SHALL advance exactly one frame.
REQ-023 HOLD: frame_sel SHALL stay NUM_FRAMES, tick_cnt SHALL stay 0, busy=0, and frame_tick and skip SHALL be ignored.
REQ-024 In any state, status!=ACTIVE_STATUS SHALL force IDLE on the next cycle with frame_sel=0 and tick_cnt=0; this SHALL NOT generate anim_done, and the condition takes priority over tick and skip.
REQ-025 Re-entry of ACTIVE_STATUS after IDLE SHALL restart the sequence from frame 1.
REQ-026 skip or frame_tick received in IDLE SHALL have no effect.
REQ-027 All outputs SHALL be driven directly from registers, with no combinational path from any input.

Reset
REQ-028 Reset=1 at a rising Clk edge SHALL force IDLE with frame_sel=0, tick_cnt=0, busy=0 and anim_done=0, overriding all other inputs, including mid-PLAY.
REQ-029 After Reset is released, if status==ACTIVE_STATUS, the block SHALL enter PLAY on the following edge.

Verification
REQ-030 Nominal: defaults, status=5 held, 360 ticks -> frame_sel 1 (ticks 1-120), 2 (121-240), 3; anim_done pulses once after tick 360; HOLD thereafter.
REQ-031 Skip: skip pulse in PLAY at frame 1 with tick_cnt=50 -> frame_sel=2 and tick_cnt=0 next cycle; skip coincident with the 120th tick -> frame_sel advances by one only.
REQ-032 Pause: pause=1 for 30 ticks at tick_cnt=10 -> tick_cnt stays 10; with pause=0, the frame changes after 110 further ticks.
REQ-033 Abort: status changes 5->2 during frame 2 -> next cycle frame_sel=0, tick_cnt=0, no anim_done; status back to 5 -> frame_sel=1.
REQ-034 Loop: LOOP=1, NUM_FRAMES=3, FRAME_TICKS=2 -> frame_sel sequence 1,1,2,2,3,3,1,... with anim_done never asserted.
REQ-035 Reset: Reset pulse during PLAY at frame 3 with tick_cnt=7 and status=5 -> IDLE for one cycle, then PLAY with frame_sel=1.

Source files
------------

// File: rtl/flower_anim_ctrl.sv
// Flower sprite animation sequencer: steps through NUM_FRAMES sprite frames while the
// game is in ACTIVE_STATUS, then holds the last frame or loops back to frame 1.
module flower_anim_ctrl #(
   parameter logic [3:0] ACTIVE_STATUS = 4'd5,
   parameter int         NUM_FRAMES    = 3,
   parameter int         FRAME_TICKS   = 120,
   parameter int         LOOP          = 0
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic [3:0] status,
   input  logic       pause,
   input  logic       skip,
   output logic [2:0] frame_sel,
   output logic [7:0] tick_cnt,
   output logic       busy,
   output logic       anim_done
);

   localparam logic [2:0] LAST_FRAME = 3'(NUM_FRAMES);
   localparam logic [7:0] LAST_TICK  = 8'(FRAME_TICKS - 1);

   typedef enum logic [1:0] {
      IDLE,
      PLAY,
      HOLD
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] frame_sel_q, frame_sel_d;
   logic [7:0] tick_cnt_q, tick_cnt_d;
   logic       busy_q, busy_d;
   logic       anim_done_q, anim_done_d;

   logic tick_en;
   logic expire;
   logic advance;

   assign tick_en = frame_tick && !pause;
   assign expire  = tick_en && (tick_cnt_q == LAST_TICK);
   // skip and expiry collapse into a single advance, so coincident events move one frame
   assign advance = skip || expire;

   always_comb begin
      state_d     = state_q;
      frame_sel_d = frame_sel_q;
      tick_cnt_d  = tick_cnt_q;
      busy_d      = busy_q;
      anim_done_d = 1'b0;

      // Leaving the active status aborts from any state without flagging completion
      if (status != ACTIVE_STATUS) begin
         state_d     = IDLE;
         frame_sel_d = 3'd0;
         tick_cnt_d  = 8'd0;
         busy_d      = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d     = PLAY;
               frame_sel_d = 3'd1;
               tick_cnt_d  = 8'd0;
               busy_d      = 1'b1;
            end
            PLAY: begin
               if (advance) begin
                  tick_cnt_d = 8'd0;
                  if (frame_sel_q < LAST_FRAME) begin
                     frame_sel_d = frame_sel_q + 3'd1;
                  end else if (LOOP != 0) begin
                     frame_sel_d = 3'd1;
                  end else begin
                     state_d     = HOLD;
                     busy_d      = 1'b0;
                     anim_done_d = 1'b1;
                  end
               end else if (tick_en) begin
                  tick_cnt_d = tick_cnt_q + 8'd1;
               end
            end
            HOLD: begin
               frame_sel_d = LAST_FRAME;
               tick_cnt_d  = 8'd0;
               busy_d      = 1'b0;
            end
            default: begin
               state_d     = IDLE;
               frame_sel_d = 3'd0;
               tick_cnt_d  = 8'd0;
               busy_d      = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= IDLE;
         frame_sel_q <= 3'd0;
         tick_cnt_q  <= 8'd0;
         busy_q      <= 1'b0;
         anim_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_sel_q <= frame_sel_d;
         tick_cnt_q  <= tick_cnt_d;
         busy_q      <= busy_d;
         anim_done_q <= anim_done_d;
      end
   end

   assign frame_sel = frame_sel_q;
   assign tick_cnt  = tick_cnt_q;
   assign busy      = busy_q;
   assign anim_done = anim_done_q;

endmodule
